// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared types for the ALU arbiter
// Purpose: ALU opcode encodings, arbiter FSM state encoding and the
//          id-width helper used by the top and the round-robin picker.
// Ports:   none (package)
package alu_arbiter_pkg;

  localparam int ALU_W = 32;
  localparam int OPC_W = 3;

  typedef enum logic [OPC_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SRA = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAPT = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// rtl/alu_arbiter_rr.sv - combinational round-robin picker
// Purpose: picks the first requester at or after (ptr+1) mod NREQ, wrapping
//          at NREQ (not at 2^IDW), and returns it one-hot and as an index.
// Ports:   i_req        request vector
//          i_ptr        index of the previous winner
//          o_grant      one-hot winner (all zero when no request)
//          o_grant_idx  winner index
//          o_grant_any  at least one request present
module alu_arbiter_rr #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_grant_idx,
  output logic            o_grant_any
);

  int w_best;
  int w_dist;

  // Rank every requester by its distance behind the pointer; the nearest
  // one wins. Distance 0 is the slot right after the previous winner, so the
  // previous winner itself has the largest distance and goes last.
  always_comb begin
    w_best      = NREQ;
    w_dist      = 0;
    o_grant_idx = '0;
    o_grant_any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (i > int'(i_ptr)) begin
        w_dist = i - int'(i_ptr) - 1;
      end else begin
        w_dist = i + NREQ - int'(i_ptr) - 1;
      end
      if (i_req[i] && (w_dist < w_best)) begin
        w_best      = w_dist;
        o_grant_idx = IDW'(i);
        o_grant_any = 1'b1;
      end
    end
  end

  always_comb begin
    o_grant = '0;
    for (int i = 0; i < NREQ; i++) begin
      o_grant[i] = o_grant_any && (o_grant_idx == IDW'(i));
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one registered ALU
// Purpose: arbitrates NREQ requesters onto a single ALU with one-edge
//          latency, captures result and flags, and returns them on a
//          valid/ready channel tagged with the owner's index.
// Ports:   clock, reset_n                 clock, synchronous active-low reset
//          req_valid/req_ready            per-requester handshake (ready one-hot)
//          req_opcode/req_op_0/req_op_1   packed per-requester payload
//          rsp_valid/rsp_ready            response handshake
//          rsp_id/rsp_out/rsp_zero/rsp_negative  response payload
//          alu_opcode/alu_op_0/alu_op_1   registered ALU inputs
//          alu_out/alu_zero/alu_negative  ALU outputs
//          busy                           FSM not idle
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [OPC_W*NREQ-1:0]   req_opcode,
  input  logic [ALU_W*NREQ-1:0]   req_op_0,
  input  logic [ALU_W*NREQ-1:0]   req_op_1,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [ALU_W-1:0]        rsp_out,
  output logic                    rsp_zero,
  output logic                    rsp_negative,
  output logic [OPC_W-1:0]        alu_opcode,
  output logic [ALU_W-1:0]        alu_op_0,
  output logic [ALU_W-1:0]        alu_op_1,
  input  logic [ALU_W-1:0]        alu_out,
  input  logic                    alu_zero,
  input  logic                    alu_negative,
  output logic                    busy
);

  arb_state_e       r_state;
  logic [IDW-1:0]   r_ptr;
  logic             r_rsp_valid;
  logic [IDW-1:0]   r_rsp_id;
  logic [ALU_W-1:0] r_rsp_out;
  logic             r_rsp_zero;
  logic             r_rsp_negative;
  logic [OPC_W-1:0] r_alu_opcode;
  logic [ALU_W-1:0] r_alu_op_0;
  logic [ALU_W-1:0] r_alu_op_1;

  logic             w_can_grant;
  logic             w_take;
  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_grant_idx;
  logic             w_grant_any;
  logic [OPC_W-1:0] w_sel_opcode;
  logic [ALU_W-1:0] w_sel_op_0;
  logic [ALU_W-1:0] w_sel_op_1;

  alu_arbiter_rr #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .i_req       (req_valid),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_grant_any (w_grant_any)
  );

  // A grant is possible when idle, or when the pending response is being
  // consumed this cycle (back-to-back). Reset masks it so nothing is
  // accepted while the block is being cleared.
  assign w_can_grant = reset_n &&
                       ((r_state == ST_IDLE) ||
                        ((r_state == ST_RESP) && rsp_ready));
  assign w_take      = w_can_grant && w_grant_any;
  assign req_ready   = w_can_grant ? w_grant : '0;

  // Payload of the winning requester.
  always_comb begin
    w_sel_opcode = '0;
    w_sel_op_0   = '0;
    w_sel_op_1   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_opcode = req_opcode[OPC_W*i +: OPC_W];
        w_sel_op_0   = req_op_0[ALU_W*i +: ALU_W];
        w_sel_op_1   = req_op_1[ALU_W*i +: ALU_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_ptr          <= IDW'(NREQ - 1);
      r_rsp_valid    <= 1'b0;
      r_rsp_id       <= '0;
      r_rsp_out      <= '0;
      r_rsp_zero     <= 1'b1;
      r_rsp_negative <= 1'b0;
      r_alu_opcode   <= ALU_ADD;
      r_alu_op_0     <= '0;
      r_alu_op_1     <= '0;
    end else begin
      // Accepting a request loads the ALU inputs and the owner tag. In RESP
      // this coincides with the current response being consumed, so the
      // old tag is no longer needed.
      if (w_take) begin
        r_alu_opcode <= w_sel_opcode;
        r_alu_op_0   <= w_sel_op_0;
        r_alu_op_1   <= w_sel_op_1;
        r_rsp_id     <= w_grant_idx;
        r_ptr        <= w_grant_idx;
      end
      case (r_state)
        ST_IDLE: begin
          r_state <= w_take ? ST_EXEC : ST_IDLE;
        end
        ST_EXEC: begin
          // ALU registers its result at this edge.
          r_state <= ST_CAPT;
        end
        ST_CAPT: begin
          r_rsp_out      <= alu_out;
          r_rsp_zero     <= alu_zero;
          r_rsp_negative <= alu_negative;
          r_rsp_valid    <= 1'b1;
          r_state        <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= w_take ? ST_EXEC : ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_rsp_id;
  assign rsp_out      = r_rsp_out;
  assign rsp_zero     = r_rsp_zero;
  assign rsp_negative = r_rsp_negative;
  assign alu_opcode   = r_alu_opcode;
  assign alu_op_0     = r_alu_op_0;
  assign alu_op_1     = r_alu_op_1;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a bench-side ALU
module tb_alu_arbiter;

  localparam int NREQ = 3;
  localparam int IDW  = 2;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_SRA = 3'd7;

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [3*NREQ-1:0]    req_opcode;
  logic [32*NREQ-1:0]   req_op_0;
  logic [32*NREQ-1:0]   req_op_1;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [31:0]          rsp_out;
  logic                 rsp_zero;
  logic                 rsp_negative;
  logic [2:0]           alu_opcode;
  logic [31:0]          alu_op_0;
  logic [31:0]          alu_op_1;
  logic [31:0]          alu_out = 32'd0;
  logic                 alu_zero = 1'b1;
  logic                 alu_negative = 1'b0;
  logic                 busy;
  logic [31:0]          alu_next;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_op_0(req_op_0), .req_op_1(req_op_1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_zero(rsp_zero), .rsp_negative(rsp_negative),
    .alu_opcode(alu_opcode), .alu_op_0(alu_op_0), .alu_op_1(alu_op_1),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_negative(alu_negative),
    .busy(busy)
  );

  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      default: return $unsigned($signed(a) >>> b[4:0]);
    endcase
  endfunction

  // Registered ALU: result appears one edge after its inputs.
  assign alu_next = alu_fn(alu_opcode, alu_op_0, alu_op_1);
  always @(posedge clock) begin
    alu_out      <= alu_next;
    alu_zero     <= (alu_next == 32'd0);
    alu_negative <= alu_next[31];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid  = '0;
    req_opcode = '0;
    req_op_0   = '0;
    req_op_1   = '0;
    rsp_ready  = 1'b0;
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid[i]          = v;
    req_opcode[3*i +: 3]  = op;
    req_op_0[32*i +: 32]  = a;
    req_op_1[32*i +: 32]  = b;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = '1; req_opcode = '1; req_op_0 = '1; req_op_1 = '1; rsp_ready = 1'b1;
    reset_n = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (req_ready !== 3'b000) begin n_errors++; $display("FAIL reset_req_ready: got %b expected 000", req_ready); end
    n_checks++; if ({rsp_id, rsp_out, rsp_zero, rsp_negative} !== {2'd0, 32'd0, 1'b1, 1'b0})
      begin n_errors++; $display("FAIL reset_rsp_fields: got id=%0d out=%h z=%b n=%b expected id=0 out=0 z=1 n=0", rsp_id, rsp_out, rsp_zero, rsp_negative); end
    n_checks++; if ({alu_opcode, alu_op_0, alu_op_1} !== 67'd0)
      begin n_errors++; $display("FAIL reset_alu_inputs: got op=%b a=%h b=%h expected all zero", alu_opcode, alu_op_0, alu_op_1); end
    // Bring up, accept one request, then reset again while in EXEC.
    clear_inputs();
    reset_n = 1'b1;
    set_req(0, 1'b1, OP_ADD, 32'd1, 32'd1);
    #1;
    n_checks++; if (req_ready !== 3'b001) begin n_errors++; $display("FAIL reset_first_grant: got %b expected 001", req_ready); end
    tick();
    req_valid = '0;
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL reset_exec_busy: got %b expected 1", busy); end
    req_valid = '1; req_opcode = '1; req_op_0 = '1; req_op_1 = '1; rsp_ready = 1'b1;
    reset_n = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_midexec_idle: got busy=%b expected 0", busy); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_midexec_rsp_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (alu_opcode !== 3'b000) begin n_errors++; $display("FAIL reset_midexec_opcode: got %b expected 000", alu_opcode); end
    clear_inputs();
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_no_rsp: cycle %0d got %b expected 0", c, rsp_valid); end
    end
  endtask

  task automatic test_single();
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 1'b1, OP_ADD, 32'd5, 32'd7);
    #1;
    n_checks++; if (req_ready !== 3'b001) begin n_errors++; $display("FAIL single_grant: got %b expected 001", req_ready); end
    tick();
    req_valid = '0;
    for (int c = 1; c < 3; c++) begin
      n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL single_early_rsp: t+%0d got %b expected 0", c, rsp_valid); end
      tick();
    end
    n_checks++; if (rsp_valid !== 1'b1) begin n_errors++; $display("FAIL single_rsp_valid_t3: got %b expected 1", rsp_valid); end
    n_checks++; if ({rsp_id, rsp_out, rsp_zero, rsp_negative} !== {2'd0, 32'd12, 1'b0, 1'b0})
      begin n_errors++; $display("FAIL single_rsp: got id=%0d out=%h z=%b n=%b expected id=0 out=c z=0 n=0", rsp_id, rsp_out, rsp_zero, rsp_negative); end
    tick();
    n_checks++; if ({rsp_valid, busy} !== 2'b00) begin n_errors++; $display("FAIL single_drain: got valid=%b busy=%b expected 0 0", rsp_valid, busy); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_rdy;
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 1'b1, OP_SUB, 32'd3, 32'd3);
    set_req(1, 1'b1, OP_SRA, 32'h8000_0000, 32'd4);
    for (int c = 0; c < 10; c++) begin
      if (c == 9) req_valid = '0;
      #1;
      exp_rdy = (c == 0 || c == 6) ? 3'b001 : (c == 3) ? 3'b010 : 3'b000;
      n_checks++; if (req_ready !== exp_rdy) begin n_errors++; $display("FAIL b2b_grant: cycle %0d got %b expected %b", c, req_ready, exp_rdy); end
      n_checks++; if (rsp_valid !== (c == 3 || c == 6 || c == 9)) begin n_errors++; $display("FAIL b2b_rsp_valid: cycle %0d got %b", c, rsp_valid); end
      if (c == 3 || c == 9) begin
        n_checks++; if ({rsp_id, rsp_out, rsp_zero, rsp_negative} !== {2'd0, 32'd0, 1'b1, 1'b0})
          begin n_errors++; $display("FAIL b2b_rsp_id0: cycle %0d got id=%0d out=%h z=%b n=%b expected id=0 out=0 z=1 n=0", c, rsp_id, rsp_out, rsp_zero, rsp_negative); end
      end
      if (c == 6) begin
        n_checks++; if ({rsp_id, rsp_out, rsp_zero, rsp_negative} !== {2'd1, 32'hF800_0000, 1'b0, 1'b1})
          begin n_errors++; $display("FAIL b2b_rsp_id1: got id=%0d out=%h z=%b n=%b expected id=1 out=f8000000 z=0 n=1", rsp_id, rsp_out, rsp_zero, rsp_negative); end
      end
      tick();
    end
    n_checks++; if ({rsp_valid, busy} !== 2'b00) begin n_errors++; $display("FAIL b2b_drain: got valid=%b busy=%b expected 0 0", rsp_valid, busy); end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(0, 1'b1, OP_XOR, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    #1;
    n_checks++; if (req_ready !== 3'b001) begin n_errors++; $display("FAIL bp_first_grant: got %b expected 001", req_ready); end
    tick();
    set_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
    set_req(1, 1'b1, OP_ADD, 32'd1, 32'd2);
    for (int c = 1; c < 8; c++) begin
      #1;
      n_checks++; if (req_ready !== 3'b000) begin n_errors++; $display("FAIL bp_no_grant: cycle %0d got %b expected 000", c, req_ready); end
      if (c >= 3) begin
        n_checks++; if ({rsp_valid, rsp_id, rsp_out, rsp_zero, rsp_negative} !== {1'b1, 2'd0, 32'hFFFF_FFFF, 1'b0, 1'b1})
          begin n_errors++; $display("FAIL bp_rsp_stable: cycle %0d got v=%b id=%0d out=%h z=%b n=%b expected v=1 id=0 out=ffffffff z=0 n=1", c, rsp_valid, rsp_id, rsp_out, rsp_zero, rsp_negative); end
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 3'b010) begin n_errors++; $display("FAIL bp_grant_on_ready: got %b expected 010", req_ready); end
    tick();
    req_valid = '0;
    tick();
    tick();
    n_checks++; if ({rsp_valid, rsp_id, rsp_out} !== {1'b1, 2'd1, 32'd3})
      begin n_errors++; $display("FAIL bp_second_rsp: got v=%b id=%0d out=%h expected v=1 id=1 out=3", rsp_valid, rsp_id, rsp_out); end
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL bp_drain: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_wrap();
    do_reset();
    rsp_ready = 1'b1;
    set_req(2, 1'b1, OP_SUB, 32'd10, 32'd3);
    #1;
    n_checks++; if (req_ready !== 3'b100) begin n_errors++; $display("FAIL wrap_grant2: got %b expected 100", req_ready); end
    tick();
    req_valid = '0;
    tick();
    tick();
    set_req(0, 1'b1, OP_AND, 32'h0000_00FF, 32'h0000_000F);
    set_req(2, 1'b1, OP_OR, 32'h1000_0000, 32'h0000_0001);
    #1;
    n_checks++; if ({rsp_valid, rsp_id, rsp_out} !== {1'b1, 2'd2, 32'd7})
      begin n_errors++; $display("FAIL wrap_rsp2: got v=%b id=%0d out=%h expected v=1 id=2 out=7", rsp_valid, rsp_id, rsp_out); end
    n_checks++; if (req_ready !== 3'b001) begin n_errors++; $display("FAIL wrap_grant0: got %b expected 001", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    tick();
    tick();
    #1;
    n_checks++; if ({rsp_valid, rsp_id, rsp_out} !== {1'b1, 2'd0, 32'h0000_000F})
      begin n_errors++; $display("FAIL wrap_rsp0: got v=%b id=%0d out=%h expected v=1 id=0 out=f", rsp_valid, rsp_id, rsp_out); end
    n_checks++; if (req_ready !== 3'b100) begin n_errors++; $display("FAIL wrap_grant2_again: got %b expected 100", req_ready); end
    tick();
    req_valid = '0;
    tick();
    tick();
    n_checks++; if ({rsp_valid, rsp_id, rsp_out} !== {1'b1, 2'd2, 32'h1000_0001})
      begin n_errors++; $display("FAIL wrap_rsp2b: got v=%b id=%0d out=%h expected v=1 id=2 out=10000001", rsp_valid, rsp_id, rsp_out); end
    tick();
  endtask

  // Random traffic against a transaction-level model: an op occupies the
  // ALU for three cycles, then its response waits for rsp_ready; a new op
  // may start when nothing is outstanding or the response is leaving.
  task automatic test_random();
    logic        m_valid [NREQ];
    logic [2:0]  m_opc   [NREQ];
    logic [31:0] m_a     [NREQ];
    logic [31:0] m_b     [NREQ];
    int          m_wait  [NREQ];
    int          m_ptr, m_age, exp_g, done, cycles, c;
    logic        m_inflight, m_rv, can;
    logic [NREQ-1:0] exp_rdy;
    logic [IDW-1:0]  e_id;
    logic [31:0]     e_out;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin m_valid[i] = 1'b0; m_wait[i] = 0; m_opc[i] = '0; m_a[i] = '0; m_b[i] = '0; end
    m_ptr = NREQ - 1; m_inflight = 1'b0; m_age = 0; done = 0; cycles = 0;
    e_id = '0; e_out = '0;
    while (done < 10000 && cycles < 70000) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!m_valid[i]) begin
          if ($urandom_range(1, 0) == 1) begin
            m_valid[i] = 1'b1;
            m_opc[i]   = 3'($urandom_range(7, 0));
            m_a[i]     = $urandom;
            m_b[i]     = ($urandom_range(3, 0) == 0) ? m_a[i] : $urandom;
            m_wait[i]  = 0;
          end
        end else if ($urandom_range(15, 0) == 0) begin
          m_valid[i] = 1'b0;
          m_wait[i]  = 0;
        end
        set_req(i, m_valid[i], m_opc[i], m_a[i], m_b[i]);
      end
      rsp_ready = ($urandom_range(3, 0) != 0);
      #1;
      m_rv = m_inflight && (m_age >= 3);
      can  = !m_inflight || (m_rv && rsp_ready);
      exp_g = -1;
      if (can) begin
        for (int k = 1; k <= NREQ; k++) begin
          c = (m_ptr + k) % NREQ;
          if (exp_g < 0 && m_valid[c]) exp_g = c;
        end
      end
      exp_rdy = (exp_g >= 0) ? NREQ'(1 << exp_g) : '0;
      n_checks++; if (req_ready !== exp_rdy || !$onehot0(req_ready)) begin n_errors++; $display("FAIL rand_grant: cycle %0d got %b expected %b", cycles, req_ready, exp_rdy); end
      n_checks++; if (rsp_valid !== m_rv || busy !== m_inflight) begin n_errors++; $display("FAIL rand_state: cycle %0d got valid=%b busy=%b expected %b %b", cycles, rsp_valid, busy, m_rv, m_inflight); end
      if (m_rv) begin
        n_checks++; if ({rsp_id, rsp_out, rsp_zero, rsp_negative} !== {e_id, e_out, (e_out == 32'd0), e_out[31]})
          begin n_errors++; $display("FAIL rand_rsp: cycle %0d got id=%0d out=%h z=%b n=%b expected id=%0d out=%h", cycles, rsp_id, rsp_out, rsp_zero, rsp_negative, e_id, e_out); end
      end
      if (m_rv && rsp_ready) begin m_inflight = 1'b0; done++; end
      if (exp_g >= 0) begin
        m_inflight = 1'b1; m_age = 0; m_ptr = exp_g;
        e_id  = IDW'(exp_g);
        e_out = alu_fn(m_opc[exp_g], m_a[exp_g], m_b[exp_g]);
        m_valid[exp_g] = 1'b0; m_wait[exp_g] = 0;
        for (int j = 0; j < NREQ; j++) begin
          if (m_valid[j]) begin
            m_wait[j]++;
            n_checks++; if (m_wait[j] > NREQ - 1) begin n_errors++; $display("FAIL rand_starve: req %0d waited %0d ops expected at most %0d", j, m_wait[j], NREQ - 1); end
          end
        end
      end
      if (m_inflight) m_age++;
      cycles++;
      tick();
    end
    n_checks++; if (done < 10000) begin n_errors++; $display("FAIL rand_timeout: completed %0d ops expected 10000", done); end
    clear_inputs();
    rsp_ready = 1'b1;
    tick(); tick(); tick(); tick();
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
